// File: rtl/bus_arbiter.sv
// Two-port round-robin memory bus arbiter: grants one requester at a time, holds the
// memory strobe for WAIT cycles, then pulses the winner's ack for one cycle.
module bus_arbiter #(
   parameter int unsigned AW   = 13,
   parameter int unsigned DW   = 8,
   parameter int unsigned WAIT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_rd,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   localparam logic [3:0] WaitInit = 4'(WAIT - 1);

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          last_q, last_d;  // 1 = port 1 was granted last
   logic          gnt0_q, gnt0_d;
   logic          gnt1_q, gnt1_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          mem_rd_q, mem_rd_d;
   logic          mem_wr_q, mem_wr_d;
   logic          busy_q, busy_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          win;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      gnt0_d      = gnt0_q;
      gnt1_d      = gnt1_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      mem_rd_d    = mem_rd_q;
      mem_wr_d    = mem_wr_q;
      busy_d      = busy_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      win         = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               // On a tie the port not granted last wins.
               win         = (req0 && req1) ? ~last_q : req1;
               state_d     = StAccess;
               cnt_d       = WaitInit;
               last_d      = win;
               gnt0_d      = ~win;
               gnt1_d      = win;
               busy_d      = 1'b1;
               mem_addr_d  = win ? addr1 : addr0;
               mem_wdata_d = win ? wdata1 : wdata0;
               mem_wr_d    = win ? we1 : we0;
               mem_rd_d    = win ? ~we1 : ~we0;
            end
         end
         StAccess: begin
            if (cnt_q == '0) begin
               state_d  = StDone;
               ack0_d   = gnt0_q;
               ack1_d   = gnt1_q;
               gnt0_d   = 1'b0;
               gnt1_d   = 1'b0;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               if (mem_rd_q) begin
                  rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         last_q      <= 1'b1;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         busy_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         busy_q      <= busy_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign busy      = busy_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rdata     = rdata_q;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: AW, 13, address width in bits.
REQ-002 Parameter: DW, 8, data width in bits.
REQ-003 Parameter: WAIT, 2, memory access cycles per transfer (legal range 1..15).
REQ-004 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: req0  input  1  CPU requester bus request.
REQ-007 Port: we0  input  1  CPU write enable (1 = write, 0 = read).
REQ-008 Port: addr0  input  AW  CPU address.
REQ-009 Port: wdata0  input  DW  CPU write data.
REQ-010 Port: req1 / we1 / addr1 / wdata1  input  1/1/AW/DW  loader requester, same meaning as port 0.
REQ-011 Port: gnt0 / gnt1  output  1  requester owns the memory bus.
REQ-012 Port: ack0 / ack1  output  1  one-cycle transfer-complete pulse.
REQ-013 Port: rdata  output  DW  read data, valid in the ack cycle.
REQ-014 Port: mem_addr  output  AW  memory address.
REQ-015 Port: mem_wdata  output  DW  memory write data.
REQ-016 Port: mem_rd / mem_wr  output  1  memory read / write strobes.
REQ-017 Port: mem_rdata  input  DW  memory read data.
REQ-018 Port: busy  output  1  state is not IDLE.

Function
REQ-019 The block SHALL implement three states: IDLE, ACCESS, DONE. All outputs SHALL be registered.
REQ-020 IDLE: with no request, the block SHALL stay in IDLE with gnt, ack, mem_rd, mem_wr all 0.
REQ-021 IDLE: with exactly one req high, that port SHALL win arbitration.
REQ-022 IDLE: with both req high, the port not granted last SHALL win (round-robin). The last-grant pointer SHALL reset to port 1, so port 0 wins the first tie.
REQ-023 On the IDLE->ACCESS edge, the block SHALL latch the winner's addr, we and wdata into mem_addr, mem_wr/mem_rd and mem_wdata, set the winner's gnt, load the wait counter with WAIT-1, and update the last-grant pointer.
REQ-024 ACCESS: gnt, mem_addr, mem_wdata and the strobe (mem_rd xor mem_wr) SHALL be held for exactly WAIT cycles. The counter SHALL decrement each cycle; ACCESS->DONE SHALL occur when the counter is 0.
REQ-025 On the ACCESS->DONE edge of a read, the block SHALL capture mem_rdata into rdata. rdata SHALL otherwise hold its value.
REQ-026 DONE: the winner's ack SHALL be 1 for exactly one cycle. gnt, mem_rd and mem_wr SHALL be 0. The next state SHALL be IDLE unconditionally, and req SHALL be ignored in DONE.
REQ-027 Latency from req sampled in IDLE to ack SHALL be WAIT+1 cycles. Back-to-back transfers SHALL repeat every WAIT+2 cycles.
REQ-028 Requesters SHALL deassert req on the edge after ack. A req still high in IDLE SHALL start a new transfer.
REQ-029 Requester inputs are sampled only in IDLE. Changes to addr, we or wdata during ACCESS SHALL NOT affect the bus.
REQ-030 gnt0 and gnt1 SHALL never be 1 together, and mem_rd and mem_wr SHALL never be 1 together.
REQ-031 WAIT=1 SHALL give a one-cycle ACCESS.

Reset
REQ-032 While rst=1 at posedge clk, the block SHALL enter IDLE. gnt0, gnt1, ack0, ack1, mem_rd, mem_wr and busy SHALL be 0. mem_addr, mem_wdata and rdata SHALL be 0. The wait counter SHALL be 0, and the last-grant pointer SHALL be port 1.
REQ-033 rst during ACCESS or DONE SHALL abort the transfer with no ack. rst SHALL take priority over all other inputs.

Verification (WAIT=2)
REQ-034 Reset: rst=1 for 2 cycles with req0=req1=1 -> all outputs 0 and busy=0 throughout.
REQ-035 CPU read: req0=1, we0=0, addr0=0x0A5, mem_rdata=0x3C -> gnt0 and mem_rd high for 2 cycles with mem_addr=0x0A5, then ack0 pulses 1 cycle with rdata=0x3C, 3 cycles after req sampled.
REQ-036 Loader write: req1=1, we1=1, addr1=0x1FFF, wdata1=0xA5 -> mem_wr high for 2 cycles, mem_addr=0x1FFF, mem_wdata=0xA5, mem_rd=0, then a single ack1 pulse.
REQ-037 Contention: req0=req1=1 held continuously from reset release -> grants alternate 0,1,0,1 every 4 cycles; no cycle has both gnts set.
REQ-038 Abort: rst=1 in the 2nd ACCESS cycle of a CPU write -> next cycle mem_wr=0, gnt0=0, no ack0 ever; the next tie is won by port 0.
REQ-039 Input change: addr0 changed from 0x010 to 0x020 during ACCESS -> mem_addr stays 0x010 until DONE.
